// File: rtl/ula_arbitro.sv
// Two-requester arbiter in front of a shared combinational logic unit, with a response handshake and a completion counter.
// Defining ULA_ARB_RR_EN selects round-robin arbitration; the default build uses fixed priority (requester 0 wins).
module ula_arbitro #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [5:0]       req_A0,
    input  logic [5:0]       req_B0,
    input  logic [5:0]       req_A1,
    input  logic [5:0]       req_B1,
    input  logic [3:0]       req_sel0,
    input  logic [3:0]       req_sel1,
    output logic [5:0]       ula_A,
    output logic [5:0]       ula_B,
    output logic [3:0]       ula_sel,
    input  logic [5:0]       ula_saida,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [5:0]       resp_dado,
    output logic             resp_err,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_r;
    logic       id_r;
    logic [1:0] grant_s;
    logic       xfer_s;
    logic       idx_s;

`ifdef ULA_ARB_RR_EN
    logic       ptr_r;
`endif

    // Grant decision: only offered in IDLE and only to a requester that is currently asking.
    always_comb begin
        grant_s = 2'b00;
        if ((state_r == IDLE) && rst_n) begin
            case (req_valid)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
`ifdef ULA_ARB_RR_EN
                2'b11:   grant_s = ptr_r ? 2'b10 : 2'b01;
`else
                2'b11:   grant_s = 2'b01;
`endif
                default: grant_s = 2'b00;
            endcase
        end else begin
            grant_s = 2'b00;
        end
    end

    assign req_ready = grant_s;
    assign xfer_s    = |grant_s;
    assign idx_s     = grant_s[1];

    // Main sequencer: latch on transfer, drive the unit for one cycle, hold the response until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            id_r       <= 1'b0;
            ula_A      <= 6'd0;
            ula_B      <= 6'd0;
            ula_sel    <= 4'd0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_dado  <= 6'd0;
            resp_err   <= 1'b0;
            ops_done   <= '0;
`ifdef ULA_ARB_RR_EN
            ptr_r      <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (xfer_s) begin
                        ula_A   <= idx_s ? req_A1   : req_A0;
                        ula_B   <= idx_s ? req_B1   : req_B0;
                        ula_sel <= idx_s ? req_sel1 : req_sel0;
                        id_r    <= idx_s;
`ifdef ULA_ARB_RR_EN
                        ptr_r   <= ~idx_s;
`endif
                        state_r <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    // Codes with bit 3 clear are illegal: report an error and a zero result.
                    resp_dado  <= ula_sel[3] ? ula_saida : 6'd0;
                    resp_err   <= ~ula_sel[3];
                    resp_id    <= id_r;
                    resp_valid <= 1'b1;
                    ula_A      <= 6'd0;
                    ula_B      <= 6'd0;
                    ula_sel    <= 4'd0;
                    state_r    <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        ops_done   <= ops_done + CNT_W'(1);
                        state_r    <= IDLE;
                    end else begin
                        state_r    <= RESP;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    ula_A      <= 6'd0;
                    ula_B      <= 6'd0;
                    ula_sel    <= 4'd0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_arbitro.sv
// Bench for ula_arbitro: directed scenarios plus random traffic, checked every cycle against a phase-level model.
module tb_ula_arbitro;

    localparam int CW = 2;
`ifdef ULA_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [5:0]    req_A0, req_B0, req_A1, req_B1;
    logic [3:0]    req_sel0, req_sel1;
    logic [5:0]    ula_A, ula_B;
    logic [3:0]    ula_sel;
    logic [5:0]    ula_saida;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_id;
    logic [5:0]    resp_dado;
    logic          resp_err;
    logic [CW-1:0] ops_done;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Model state: phase 0 accepting, 1 computing, 2 offering response.
    int         m_phase;
    logic       m_fav;
    logic [5:0] m_a, m_b, m_dado;
    logic [3:0] m_sel;
    logic       m_id, m_rid, m_err;
    int         m_cnt;

    always #5 clk = ~clk;

    function automatic logic [5:0] ref_alu(input logic [5:0] a, input logic [5:0] b, input logic [3:0] s);
        case (s[2:0])
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~a;
            3'd4:    return a + b;
            3'd5:    return a - b;
            3'd6:    return ~(a & b);
            default: return b;
        endcase
    endfunction

    assign ula_saida = ref_alu(ula_A, ula_B, ula_sel);

    ula_arbitro #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_A0(req_A0), .req_B0(req_B0), .req_A1(req_A1), .req_B1(req_B1),
        .req_sel0(req_sel0), .req_sel1(req_sel1),
        .ula_A(ula_A), .ula_B(ula_B), .ula_sel(ula_sel), .ula_saida(ula_saida),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_dado(resp_dado), .resp_err(resp_err),
        .ops_done(ops_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_ready();
        if (m_phase != 0) return 2'b00;
        if (req_valid == 2'b11) return (RR && m_fav) ? 2'b10 : 2'b01;
        return req_valid;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_fav = 1'b0; m_cnt = 0;
        m_rid = 1'b0; m_dado = 6'd0; m_err = 1'b0;
    endtask

    task automatic check_reset();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_ula_A", 32'(ula_A), 32'd0);
        chk("rst_ula_B", 32'(ula_B), 32'd0);
        chk("rst_ula_sel", 32'(ula_sel), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_resp_dado", 32'(resp_dado), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_ops_done", 32'(ops_done), 32'd0);
    endtask

    task automatic check_outputs();
        chk("req_ready", 32'(req_ready), 32'(exp_ready()));
        chk("ula_A", 32'(ula_A), (m_phase == 1) ? 32'(m_a) : 32'd0);
        chk("ula_B", 32'(ula_B), (m_phase == 1) ? 32'(m_b) : 32'd0);
        chk("ula_sel", 32'(ula_sel), (m_phase == 1) ? 32'(m_sel) : 32'd0);
        chk("resp_valid", 32'(resp_valid), (m_phase == 2) ? 32'd1 : 32'd0);
        if (m_phase == 2) begin
            chk("resp_id", 32'(resp_id), 32'(m_rid));
            chk("resp_dado", 32'(resp_dado), 32'(m_dado));
            chk("resp_err", 32'(resp_err), 32'(m_err));
        end
        chk("ops_done", 32'(ops_done), 32'(m_cnt));
    endtask

    task automatic model_step();
        logic [1:0] g;
        if (m_phase == 0) begin
            g = exp_ready();
            if (g != 2'b00) begin
                m_id  = g[1];
                m_a   = g[1] ? req_A1 : req_A0;
                m_b   = g[1] ? req_B1 : req_B0;
                m_sel = g[1] ? req_sel1 : req_sel0;
                m_fav = ~g[1];
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_rid  = m_id;
            m_err  = ~m_sel[3];
            m_dado = m_sel[3] ? ref_alu(m_a, m_b, m_sel) : 6'd0;
            m_phase = 2;
        end else if (resp_ready) begin
            m_cnt = (m_cnt + 1) % (1 << CW);
            m_phase = 0;
        end
    endtask

    // One clock: inputs were set by the caller just after the previous edge.
    task automatic cycle();
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 2'b11; resp_ready = 1'b1;
        req_A0 = 6'd0; req_B0 = 6'd0; req_A1 = 6'd0; req_B1 = 6'd0;
        req_sel0 = 4'd0; req_sel1 = 4'd0;
        model_reset();
        m_a = 6'd0; m_b = 6'd0; m_sel = 4'd0; m_id = 1'b0;
        #12;
        check_reset();
        req_valid = 2'b00;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Requester 0, AND of 101010 and 110011.
        req_A0 = 6'b101010; req_B0 = 6'b110011; req_sel0 = 4'b1000; req_valid = 2'b01;
        cycle();
        req_valid = 2'b00;
        chk("s1_ula_sel", 32'(ula_sel), 32'h8);
        cycle();
        chk("s1_resp_dado", 32'(resp_dado), 32'b100010);
        cycles(2);
        chk("s1_ops_done", 32'(ops_done), 32'd1);

        // Both requesters held valid, then requester 0 drops.
        req_sel0 = 4'b1011; req_sel1 = 4'b1011;
        req_A0 = 6'($urandom); req_A1 = 6'($urandom);
        req_valid = 2'b11;
        cycles(12);
        req_valid = 2'b10;
        cycles(4);

        // Illegal code from requester 1.
        req_sel1 = 4'b0101; req_valid = 2'b10;
        cycle();
        req_valid = 2'b00;
        cycles(3);

        // Response held back for five cycles while both ask.
        req_valid = 2'b01; req_sel0 = 4'b1010; resp_ready = 1'b1;
        cycles(2);
        resp_ready = 1'b0; req_valid = 2'b11;
        cycles(5);
        resp_ready = 1'b1; req_valid = 2'b00;
        cycles(2);

        // Reset mid-computation, then run enough completions to wrap the counter.
        req_valid = 2'b01;
        cycle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset();
        #2 rst_n = 1'b1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        cycles(3);
        chk("s6_no_resp", 32'(resp_valid), 32'd0);
        req_valid = 2'b01;
        cycles(15);
        req_valid = 2'b00;
        cycle();
        chk("s6_wrap", 32'(ops_done), 32'd1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            req_valid  = 2'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            req_A0 = 6'($urandom); req_B0 = 6'($urandom); req_sel0 = 4'($urandom);
            req_A1 = 6'($urandom); req_B1 = 6'($urandom); req_sel1 = 4'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ula_arbitro.md
ULA_ARBITRO -- requirements
Module: ula_arbitro

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, the width of the completed-operation counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset; asynchronous, active-low.
REQ-004 The block SHALL have ports req_valid[1:0], input, 2, per-requester request strobes (requester 0 and 1).
REQ-005 The block SHALL have ports req_ready[1:0], output, 2, per-requester acceptance.
REQ-006 The block SHALL have ports req_A0/req_B0, req_A1/req_B1, input, 6 each, operands per requester.
REQ-007 The block SHALL have ports req_sel0/req_sel1, input, 4 each, operation codes per requester.
REQ-008 The block SHALL have ports ula_A, ula_B, output, 6 each, operands driven to the shared logic unit.
REQ-009 The block SHALL have port ula_sel, output, 4, operation code driven to the shared logic unit.
REQ-010 The block SHALL have port ula_saida, input, 6, combinational result returned by the logic unit.
REQ-011 The block SHALL have ports resp_valid, output, 1, and resp_ready, input, 1, the response handshake.
REQ-012 The block SHALL have ports resp_id, output, 1, and resp_dado, output, 6, the serving requester and the result.
REQ-013 The block SHALL have port resp_err, output, 1, set for an illegal code (sel[3]=0).
REQ-014 The block SHALL have port ops_done, output, CNT_W, the count of completed responses.

Function
REQ-015 The FSM SHALL have the states IDLE, EXEC and RESP.
REQ-016 In IDLE, req_ready SHALL be high only for the granted requester, and only when that requester's req_valid is high; in all other states req_ready SHALL be 00.
REQ-017 A transfer SHALL occur when req_valid[i] and req_ready[i] are both high.
REQ-018 On a transfer, the block SHALL latch A, B, sel and the requester index, and then move IDLE->EXEC.
REQ-019 In EXEC, ula_A, ula_B and ula_sel SHALL carry the latched values.
REQ-020 In any state other than EXEC, ula_A, ula_B and ula_sel SHALL be 0.
REQ-021 In EXEC, the block SHALL capture ula_saida into resp_dado (or capture 0 if the latched sel[3]=0), set resp_err = ~sel[3], and move to RESP.
REQ-022 In RESP, resp_valid SHALL be 1, and resp_id, resp_dado and resp_err SHALL be held stable until resp_ready=1.
REQ-023 On resp_valid and resp_ready both high, the block SHALL clear resp_valid, increment ops_done (wrapping modulo 2^CNT_W), and return to IDLE.
REQ-024 Latency SHALL be: transfer in cycle N, EXEC in cycle N+1, resp_valid high from cycle N+2; minimum issue interval 3 cycles.
REQ-025 With both req_valid high in IDLE, exactly one requester SHALL be granted, chosen per REQ-031/032; the loser SHALL keep its request pending with no loss.
REQ-026 Deassertion of req_valid before a transfer SHALL be legal, and SHALL produce no transfer.
REQ-027 Request inputs SHALL be ignored in EXEC and RESP.
REQ-028 resp_err SHALL NOT increment any separate counter; ops_done SHALL count all responses, including error responses.

Reset
REQ-029 When rst_n=0, the block SHALL immediately, regardless of clock, force: state IDLE, req_ready=00, ula_A=ula_B=0, ula_sel=0, resp_valid=0, resp_id=0, resp_dado=0, resp_err=0, ops_done=0, and round-robin pointer=0 (requester 0 favoured).
REQ-030 A reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response SHALL be emitted after release.

Configuration
REQ-031 With macro ULA_ARB_RR_EN defined, arbitration SHALL be round-robin: the pointer SHALL toggle to the other requester after each transfer, and the favoured requester SHALL win a tie.
REQ-032 Without ULA_ARB_RR_EN, arbitration SHALL be fixed priority: requester 0 SHALL always win a tie, and no pointer SHALL exist.

Verification
REQ-033 Scenario 1: after reset, requester 0 sends A=6'b101010, B=6'b110011, sel=4'b1000 with resp_ready=1 -> ula_sel=1000 in cycle N+1; resp_valid in N+2 with resp_dado=6'b100010, resp_id=0, resp_err=0; ops_done=1.
REQ-034 Scenario 2 (ULA_ARB_RR_EN defined): both requesters hold valid continuously with sel=4'b1011 -> grants alternate 0,1,0,1; four responses arrive with resp_id 0,1,0,1.
REQ-035 Scenario 3 (macro undefined): same stimulus as Scenario 2 -> every grant goes to 0 while it is valid; requester 1 is granted only after req_valid[0] drops.
REQ-036 Scenario 4: requester 1 sends sel=4'b0101 -> resp_err=1 and resp_dado=0; ops_done increments.
REQ-037 Scenario 5: resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_dado stay stable and req_ready stays 00; after resp_ready=1 for one cycle, state returns to IDLE.
REQ-038 Scenario 6: rst_n pulsed low mid-EXEC -> outputs reach reset values before the next clock edge; resp_valid stays 0; with CNT_W=2, the fifth completion reads ops_done=1 (wrap).
